// File: rtl/usb_playback_pkg.sv
// Shared types and constants for the USB playback unpacker.
package usb_playback_pkg;

    typedef enum logic [1:0] {IDLE, PRIME, PLAY, UNDER} pb_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * SAMPLE_W;

    // Byte idx of a packed word; byte 0 is the first sample played.
    function automatic logic [SAMPLE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                      input logic [1:0]        idx);
        return w[SAMPLE_W*idx +: SAMPLE_W];
    endfunction

endpackage

// File: rtl/usb_playback_unpacker_if.sv
// USB read-path write bus into the playback unpacker.
interface usb_playback_unpacker_if;

    logic [31:0] usb_rd_data;
    logic        usb_rd_data_valid;
    logic        usb_rd_full;

    modport master (
        output usb_rd_data,
        output usb_rd_data_valid,
        input  usb_rd_full
    );

    modport slave (
        input  usb_rd_data,
        input  usb_rd_data_valid,
        output usb_rd_full
    );

endinterface

// File: rtl/pb_sync_fifo.sv
// 32-bit show-ahead synchronous FIFO: dout always shows the head word.
module pb_sync_fifo
    import usb_playback_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LEVEL_W     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [WORD_W-1:0]  din,
    input  logic               rd_en,
    input  logic               flush,
    output logic [WORD_W-1:0]  dout,
    output logic               empty,
    output logic               full,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned PTR_W = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0]  mem_q [DEPTH_WORDS];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic               wr_fire;
    logic               rd_fire;

    assign empty = (level_q == '0);
    assign full  = (level_q == LEVEL_W'(DEPTH_WORDS));
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // Flush discards any same-cycle write or read.
    assign wr_fire = wr_en & ~full & ~flush;
    assign rd_fire = rd_en & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage array; no reset needed since level gates visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/usb_playback_unpacker.sv
// Buffers 32-bit USB words and paces them out as 8-bit samples.
// Optional underrun counter enabled by defining USB_PLAYBACK_STATS_EN.
module usb_playback_unpacker
    import usb_playback_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LEVEL_W     = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    usb_playback_unpacker_if.slave usb,
    input  logic                 enable,
    input  logic                 flush,
    input  logic [15:0]          rate_div,
    input  logic [LEVEL_W-1:0]   prime_level,
    input  logic                 clr_flags,
    output logic [SAMPLE_W-1:0]  out_data,
    output logic                 out_valid,
    output logic [LEVEL_W-1:0]   level,
    output logic                 underrun,
    output logic                 overflow,
    output logic [15:0]          underrun_count
);

    pb_state_e          state_q;
    logic [1:0]         byte_idx_q;
    logic [15:0]        rate_cnt_q;
    logic [WORD_W-1:0]  fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic [LEVEL_W-1:0] fifo_level;
    logic               tick;
    logic               play_go;
    logic               play_fire;
    logic               under_evt;
    logic               ovf_evt;
    logic               pop;

    pb_sync_fifo #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LEVEL_W     (LEVEL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (usb.usb_rd_data_valid),
        .din   (usb.usb_rd_data),
        .rd_en (pop),
        .flush (flush),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign usb.usb_rd_full = fifo_full;
    assign level           = fifo_level;

    // Disable and flush both pre-empt sample production in the same edge.
    assign tick      = (state_q != IDLE) && (rate_cnt_q == 16'd0);
    assign play_go   = (state_q == PLAY) && enable && !flush && tick;
    assign play_fire = play_go && !fifo_empty;
    assign under_evt = play_go && fifo_empty;
    assign pop       = play_fire && (byte_idx_q == 2'd3);
    assign ovf_evt   = usb.usb_rd_data_valid && fifo_full;

    // Sample-period down-counter; parked at 0 in IDLE so the first tick is immediate.
    always_ff @(posedge clk) begin
        if (reset || state_q == IDLE) begin
            rate_cnt_q <= 16'd0;
        end else if (rate_cnt_q == 16'd0) begin
            rate_cnt_q <= rate_div;
        end else begin
            rate_cnt_q <= rate_cnt_q - 16'd1;
        end
    end

    // Playback FSM with registered sample output and byte index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            out_data   <= '0;
            out_valid  <= 1'b0;
            byte_idx_q <= 2'd0;
        end else begin
            out_valid <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
            end else if (flush) begin
                if (state_q == PLAY) state_q <= PRIME;
            end else begin
                unique case (state_q)
                    IDLE: state_q <= PRIME;
                    PRIME, UNDER: begin
                        if (fifo_level >= prime_level) state_q <= PLAY;
                    end
                    PLAY: begin
                        if (play_fire) begin
                            out_data  <= word_byte(fifo_dout, byte_idx_q);
                            out_valid <= 1'b1;
                        end else if (under_evt) begin
                            state_q <= UNDER;
                        end
                    end
                endcase
            end

            // Index survives disable so a resumed word continues mid-way.
            if (flush) begin
                byte_idx_q <= 2'd0;
            end else if (play_fire) begin
                byte_idx_q <= byte_idx_q + 2'd1;
            end
        end
    end

    // Sticky flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            underrun <= (underrun && !clr_flags) || under_evt;
            overflow <= (overflow && !clr_flags) || ovf_evt;
        end
    end

`ifdef USB_PLAYBACK_STATS_EN
    logic [15:0] under_cnt_q;

    // Saturating count of PLAY->UNDER transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            under_cnt_q <= 16'd0;
        end else if (clr_flags) begin
            under_cnt_q <= {15'd0, under_evt};
        end else if (under_evt && under_cnt_q != 16'hFFFF) begin
            under_cnt_q <= under_cnt_q + 16'd1;
        end
    end

    assign underrun_count = under_cnt_q;
`else
    assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_usb_playback_unpacker.sv
// Scoreboard bench: a byte-queue model of accepted words predicts sample order,
// occupancy, full and overflow; directed sequences cover pacing and edge cases.
module tb_usb_playback_unpacker;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          clr_flags = 1'b0;
    logic [15:0]   rate_div = 16'd0;
    logic [LW-1:0] prime_level = '0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          underrun;
    logic          overflow;
    logic [15:0]   underrun_count;

    usb_playback_unpacker_if bus ();

    usb_playback_unpacker #(
        .DEPTH_WORDS (DEPTH),
        .LEVEL_W     (LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .usb            (bus.slave),
        .enable         (enable),
        .flush          (flush),
        .rate_div       (rate_div),
        .prime_level    (prime_level),
        .clr_flags      (clr_flags),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .level          (level),
        .underrun       (underrun),
        .overflow       (overflow),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_samples = 0;
    bit [7:0] exp_q[$];
    bit m_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: advances the model with what was applied at this edge, then compares.
    always @(posedge clk) begin
        int pre;
        bit wr_ok;
        bit [7:0] e;
        #1;
        if (reset) begin
            exp_q.delete();
            m_ovf = 1'b0;
        end else begin
            pre   = (exp_q.size() + 3) / 4;
            wr_ok = bus.usb_rd_data_valid && !flush && pre < DEPTH;
            m_ovf = (m_ovf && !clr_flags) || (bus.usb_rd_data_valid && pre == DEPTH);
            if (flush) begin
                chk("no_sample_on_flush", {31'd0, out_valid}, 32'd0);
                exp_q.delete();
            end else begin
                if (out_valid) begin
                    n_samples++;
                    if (exp_q.size() == 0) begin
                        chk("sample_without_data", {31'd0, out_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sample_order", {24'd0, out_data}, {24'd0, e});
                    end
                end
                if (wr_ok) begin
                    for (int b = 0; b < 4; b++) exp_q.push_back(bus.usb_rd_data[8*b +: 8]);
                end
            end
            chk("level", {29'd0, level}, (exp_q.size() + 3) / 4);
            chk("full", {31'd0, bus.usb_rd_full}, {31'd0, ((exp_q.size() + 3) / 4) == DEPTH});
            chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        end
    end

    task automatic write_word(input logic [31:0] w);
        @(negedge clk);
        bus.usb_rd_data       = w;
        bus.usb_rd_data_valid = 1'b1;
        @(negedge clk);
        bus.usb_rd_data_valid = 1'b0;
    endtask

    task automatic pulse_ctl(input bit do_flush, input bit do_clr);
        @(negedge clk);
        flush     = do_flush;
        clr_flags = do_clr;
        @(negedge clk);
        flush     = 1'b0;
        clr_flags = 1'b0;
    endtask

    task automatic wait_sample(input string name, input int budget,
                               output logic [7:0] d, output int at);
        bit got = 1'b0;
        d  = '0;
        at = 0;
        for (int k = 0; k < budget && !got; k++) begin
            @(posedge clk);
            #2;
            if (out_valid) begin
                got = 1'b1;
                d   = out_data;
                at  = cyc;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: got no out_valid, expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic set_en(input bit v);
        @(negedge clk);
        enable = v;
    endtask

    logic [7:0] d;
    int t [4];
    int base;
    int exp_cnt;

    initial begin
        bus.usb_rd_data       = '0;
        bus.usb_rd_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_full", {31'd0, bus.usb_rd_full}, 32'd0);
        chk("rst_flags", {30'd0, underrun, overflow}, 32'd0);
        chk("rst_count", {16'd0, underrun_count}, 32'd0);

        // Byte order and pacing.
        prime_level = 3'd1;
        rate_div    = 16'd2;
        write_word(32'h44332211);
        set_en(1'b1);
        wait_sample("t1_s0", 12, d, t[0]);
        chk("t1_byte0", {24'd0, d}, 32'h11);
        wait_sample("t1_s1", 6, d, t[1]);
        chk("t1_byte1", {24'd0, d}, 32'h22);
        wait_sample("t1_s2", 6, d, t[2]);
        chk("t1_byte2", {24'd0, d}, 32'h33);
        chk("t1_level_before_pop", {29'd0, level}, 32'd1);
        wait_sample("t1_s3", 6, d, t[3]);
        chk("t1_byte3", {24'd0, d}, 32'h44);
        chk("t1_level_after_pop", {29'd0, level}, 32'd0);
        for (int i = 1; i < 4; i++) chk("t1_pace", t[i] - t[i-1], 32'd3);

        // Underrun on the next tick with nothing buffered.
        for (int k = 0; k < 8 && !underrun; k++) @(negedge clk);
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        chk("t3_hold_data", {24'd0, out_data}, 32'h44);
        chk("t3_no_valid", {31'd0, out_valid}, 32'd0);
`ifdef USB_PLAYBACK_STATS_EN
        exp_cnt = 1;
`else
        exp_cnt = 0;
`endif
        chk("t3_count", {16'd0, underrun_count}, exp_cnt);
        pulse_ctl(1'b0, 1'b1);
        chk("t3_clr", {31'd0, underrun}, 32'd0);
        set_en(1'b0);

        // Priming: three words are not enough for prime_level 4.
        rate_div    = 16'd1;
        prime_level = 3'd4;
        set_en(1'b1);
        write_word(32'h0D0C0B0A);
        write_word(32'h1D1C1B1A);
        write_word(32'h2D2C2B2A);
        base = n_samples;
        repeat (10) @(negedge clk);
        chk("t2_no_early_play", n_samples - base, 32'd0);
        write_word(32'h3D3C3B3A);
        wait_sample("t2_first", 3, d, t[0]);
        chk("t2_first_byte", {24'd0, d}, 32'h0A);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
        chk("t2_drained", exp_q.size(), 32'd0);
        set_en(1'b0);

        // Full / overflow with playback disabled.
        pulse_ctl(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            write_word(32'hF0000000 | i);
            if (i == 2) chk("t4_not_full", {31'd0, bus.usb_rd_full}, 32'd0);
            if (i == 3) chk("t4_full", {31'd0, bus.usb_rd_full}, 32'd1);
        end
        chk("t4_overflow", {31'd0, overflow}, 32'd1);
        chk("t4_level", {29'd0, level}, 32'd4);
        pulse_ctl(1'b1, 1'b1);
        chk("t4_flushed", {29'd0, level}, 32'd0);

        // Write lands in the same edge as a pop.
        rate_div    = 16'd0;
        prime_level = 3'd2;
        write_word(32'hA3A2A1A0);
        write_word(32'hB3B2B1B0);
        set_en(1'b1);
        wait_sample("t5_s0", 8, d, t[0]);
        wait_sample("t5_s1", 2, d, t[1]);
        wait_sample("t5_s2", 2, d, t[2]);
        chk("t5_level_pre", {29'd0, level}, 32'd2);
        @(negedge clk);
        bus.usb_rd_data       = 32'hC3C2C1C0;
        bus.usb_rd_data_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("t5_pop_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_pop_byte", {24'd0, out_data}, 32'hA3);
        chk("t5_level_same", {29'd0, level}, 32'd2);
        @(negedge clk);
        bus.usb_rd_data_valid = 1'b0;
        set_en(1'b0);
        pulse_ctl(1'b1, 1'b1);

        // Mid-word disable resumes at the next byte.
        rate_div    = 16'd1;
        prime_level = 3'd1;
        write_word(32'hDDCCBBAA);
        set_en(1'b1);
        wait_sample("t6_s0", 8, d, t[0]);
        wait_sample("t6_s1", 4, d, t[1]);
        set_en(1'b0);
        base = n_samples;
        repeat (5) @(negedge clk);
        chk("t6_paused", n_samples - base, 32'd0);
        chk("t6_level_kept", {29'd0, level}, 32'd1);
        set_en(1'b1);
        wait_sample("t6_resume", 10, d, t[2]);
        chk("t6_resume_byte", {24'd0, d}, 32'hCC);
        wait_sample("t6_last", 4, d, t[3]);
        chk("t6_last_byte", {24'd0, d}, 32'hDD);

        // Same again, but flush while idle restarts at byte 0.
        write_word(32'h4D4C4B4A);
        wait_sample("t7_s0", 10, d, t[0]);
        wait_sample("t7_s1", 4, d, t[1]);
        set_en(1'b0);
        repeat (2) @(negedge clk);
        pulse_ctl(1'b1, 1'b1);
        chk("t7_flush_level", {29'd0, level}, 32'd0);
        write_word(32'h5D5C5B5A);
        set_en(1'b1);
        wait_sample("t7_restart", 10, d, t[2]);
        chk("t7_restart_byte", {24'd0, d}, 32'h5A);

        // Randomised traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) begin
                rate_div    = 16'($urandom_range(0, 3));
                prime_level = LW'($urandom_range(0, 4));
            end
            enable                = ($urandom_range(0, 15) != 0);
            bus.usb_rd_data_valid = ($urandom_range(0, 99) < 35);
            bus.usb_rd_data       = $urandom;
            flush                 = !bus.usb_rd_data_valid && ($urandom_range(0, 199) == 0);
            clr_flags             = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        bus.usb_rd_data_valid = 1'b0;
        flush                 = 1'b0;
        clr_flags             = 1'b0;
        enable                = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_playback_unpacker.md
Name: usb_playback_unpacker

Overview:
- Upstream neighbour of the DAC channel; feeds its USB mux input with 8-bit samples.
- Accepts 32-bit words from the USB read path and buffers them in a show-ahead FIFO.
- Unpacks each word into four 8-bit samples and paces them out at a programmable rate.
- Primes before playback, and detects and reports underrun and overflow.

Parameters:
- DEPTH_WORDS, 1024: FIFO depth in 32-bit words. Must be a power of two and at least 4.
- LEVEL_W, 11: width of the level counter. Equals log2(DEPTH_WORDS)+1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- usb_rd_data  in  32  packed samples; byte0 = [7:0] is played first.
- usb_rd_data_valid  in  1  write strobe.
- usb_rd_full  out  1  FIFO full; a write in this cycle is dropped.
- enable  in  1  playback enable.
- flush  in  1  one-cycle pulse; empties the FIFO and resets the byte index.
- rate_div  in  16  sample period minus 1, in clk cycles.
- prime_level  in  LEVEL_W  words required before playback starts.
- clr_flags  in  1  clears the sticky flags.
- out_data  out  8  current sample, registered.
- out_valid  out  1  one-cycle pulse when a new sample is presented.
- level  out  LEVEL_W  FIFO occupancy in words.
- underrun  out  1  sticky.
- overflow  out  1  sticky.
- underrun_count  out  16  see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE.
  - out_data, out_valid, level, flags, counters, byte_idx and rate counter = 0.
  - FIFO is emptied.
  - usb_rd_full = 0.
- FIFO write:
  - A write is accepted when usb_rd_data_valid=1 and usb_rd_full=0.
  - usb_rd_full = (level == DEPTH_WORDS), derived from the registered level.
  - A write while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo DEPTH_WORDS.
- Rate tick:
  - The down-counter reloads to rate_div when it reaches 0; tick = (counter == 0).
  - rate_div=0 gives a tick every cycle.
  - The counter runs only in the PRIME, PLAY and UNDER states. It is forced to 0 in IDLE, so the first tick occurs in the first cycle after leaving IDLE.
  - A change to rate_div takes effect at the next reload.
- State machine:
  - IDLE:
    - out_valid=0; out_data holds its last value.
    - enable=1 -> PRIME.
  - PRIME:
    - No output.
    - When level >= prime_level -> PLAY. prime_level=0 moves to PLAY immediately.
  - PLAY, on a tick with the FIFO non-empty:
    - out_data <= head[8*byte_idx +: 8] and out_valid=1 on the next edge (latency 1 from the tick).
    - byte_idx increments.
    - When byte_idx is 3, the head word is popped and byte_idx wraps to 0.
  - PLAY, on a tick with the FIFO empty:
    - Set underrun; out_data holds its last sample; out_valid=0; -> UNDER.
  - UNDER:
    - Behaves as PRIME: wait for level >= prime_level, then -> PLAY.
    - byte_idx is preserved; a partially consumed word cannot exist in this state.
- enable=0 in any state -> IDLE on the next edge. The FIFO contents are kept, and byte_idx is kept so that resuming continues mid-word.
- flush:
  - In the same edge: level=0, pointers=0, byte_idx=0.
  - A write in the same cycle as flush is discarded.
  - State is unchanged, except PLAY -> PRIME.
- clr_flags:
  - Clears underrun and overflow.
  - A simultaneous new event wins: the flag stays set.

Optional Feature:
- Macro: USB_PLAYBACK_STATS_EN.
- When defined:
  - underrun_count increments on each PLAY->UNDER transition and saturates at 0xFFFF.
  - It is cleared by clr_flags or reset. A simultaneous increment and clr_flags yields 1.
- When undefined: underrun_count is tied to 0 and no counter logic is generated.

Decomposition:
- Package usb_playback_pkg:
  - State enum {IDLE, PRIME, PLAY, UNDER}.
  - BYTES_PER_WORD = 4.
  - Sample width constant = 8.
- Sub-module pb_sync_fifo: 32-bit show-ahead synchronous FIFO.
  - Ports: wr_en, din, rd_en, flush, dout, empty, full, level.
  - Parameterised by DEPTH_WORDS.
  - Owns the pointers and the level counter.

Test Plan:
- Byte order and pacing: reset; write 0x44332211; enable=1, prime_level=1, rate_div=2 -> out_valid pulses every 3 cycles with 0x11, 0x22, 0x33, 0x44. level goes 1 -> 0 after the fourth sample.
- Priming: prime_level=4; write 3 words -> state stays PRIME with no out_valid. Write a 4th word -> the first sample appears within rate_div+2 cycles.
- Underrun: after the 4 samples of one word with no further writes, the next tick sets underrun=1, out_data holds 0x44, state is UNDER, and underrun_count=1 (with the macro). clr_flags -> underrun=0.
- Full/overflow (DEPTH_WORDS=4, enable=0): write 5 words -> usb_rd_full=1 after the 4th write, the 5th is dropped, overflow=1, level=4.
- Simultaneous write and pop at level=2 with rate_div=0 -> level stays 2 across the popping cycle.
- Mid-word disable and flush: disable after 2 samples of 0xDDCCBBAA, re-enable -> playback resumes with 0xCC. Repeat with flush during IDLE -> level=0, and the next word starts at byte0.
